// File: rtl/sha3_padder.sv
// SHA3-512 padder: packs 64-bit message words into 576-bit absorb blocks,
// applies pad10*1 with domain byte 0x06 and hands each block to the permutation core.
//
// state  | meaning
// ABSORB | accepting message words from the host
// PAD    | zero/0x80 fill after the last word; cnt==9 here means the final block
// DONE   | final block consumed, idle until reset
module sha3_padder (
   input  logic         clk,
   input  logic         rst,
   input  logic [63:0]  in,
   input  logic         in_ready,
   input  logic         is_last,
   input  logic [2:0]   byte_num,
   output logic         buffer_full,
   output logic [575:0] out,
   output logic         out_ready,
   input  logic         f_ack
);

   typedef enum logic [1:0] {ABSORB, PAD, DONE} state_t;

   state_t         state, state_nxt;
   logic [3:0]     cnt, cnt_nxt;
   logic [575:0]   out_nxt;
   logic [5:0]     keep_bits;
   logic [63:0]    keep_mask;
   logic [63:0]    domain_word;
   logic [63:0]    last_word;
   logic           blk_full;

   assign blk_full    = (cnt == 4'd9);
   assign buffer_full = blk_full | (state != ABSORB);
   assign out_ready   = blk_full & (state != DONE);

   // Byte k of the last word gets 0x06; a last word landing in slot 9 also carries the closing 0x80.
   assign keep_bits   = {byte_num, 3'b000};
   assign keep_mask   = ~(64'hFFFF_FFFF_FFFF_FFFF >> keep_bits);
   assign domain_word = 64'h0600_0000_0000_0000 >> keep_bits;
   assign last_word   = (in & keep_mask) | domain_word | ((cnt == 4'd8) ? 64'h80 : 64'h0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ABSORB;
         cnt   <= 4'd0;
         out   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         out   <= out_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_nxt   = out;
      case (state)
         ABSORB: begin
            if (blk_full) begin
               if (f_ack) cnt_nxt = 4'd0;
            end else if (in_ready) begin
               cnt_nxt = cnt + 4'd1;
               if (is_last) begin
                  out_nxt   = {out[511:0], last_word};
                  state_nxt = PAD;
               end else begin
                  out_nxt = {out[511:0], in};
               end
            end
         end
         PAD: begin
            if (blk_full) begin
               if (f_ack) begin
                  cnt_nxt   = 4'd0;
                  state_nxt = DONE;
               end
            end else begin
               cnt_nxt = cnt + 4'd1;
               out_nxt = {out[511:0], (cnt == 4'd8) ? 64'h80 : 64'h0};
            end
         end
         DONE: begin
         end
         default: state_nxt = ABSORB;
      endcase
   end

endmodule

// File: tb/tb_sha3_padder.sv
// Directed bench for sha3_padder: empty, short, 71-byte, 72-byte messages,
// stray acks, ignored host words and asynchronous reset.
module tb_sha3_padder;

   logic         clk;
   logic         rst;
   logic [63:0]  in_d;
   logic         in_ready;
   logic         is_last;
   logic [2:0]   byte_num;
   logic         buffer_full;
   logic [575:0] out;
   logic         out_ready;
   logic         f_ack;

   int n_tests;
   int n_fail;
   logic [63:0] ew [9];

   sha3_padder dut (
      .clk         (clk),
      .rst         (rst),
      .in          (in_d),
      .in_ready    (in_ready),
      .is_last     (is_last),
      .byte_num    (byte_num),
      .buffer_full (buffer_full),
      .out         (out),
      .out_ready   (out_ready),
      .f_ack       (f_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [575:0] packw();
      logic [575:0] r;
      r = '0;
      for (int i = 0; i < 9; i++) r = {r[511:0], ew[i]};
      return r;
   endfunction

   task automatic clr_ew();
      for (int i = 0; i < 9; i++) ew[i] = 64'h0;
   endtask

   task automatic put(input logic [63:0] w, input logic last, input logic [2:0] k);
      @(negedge clk);
      in_d = w; in_ready = 1'b1; is_last = last; byte_num = k;
      @(posedge clk); #1;
      in_ready = 1'b0; is_last = 1'b0; byte_num = 3'd0;
   endtask

   task automatic ack();
      @(negedge clk);
      f_ack = 1'b1;
      @(posedge clk); #1;
      f_ack = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #2;
      chk("rst_out",         out,         576'h0);
      chk("rst_out_ready",   out_ready,   576'h0);
      chk("rst_buffer_full", buffer_full, 576'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b1; in_d = '0; in_ready = 0; is_last = 0; byte_num = 0; f_ack = 0;
      #12;
      chk("reset_out",         out,         576'h0);
      chk("reset_out_ready",   out_ready,   576'h0);
      chk("reset_buffer_full", buffer_full, 576'h0);
      rst = 1'b0;

      // empty message: data bits must be masked off entirely
      put(64'hDEAD_BEEF_0123_4567, 1'b1, 3'd0);
      chk("empty_pad_bf", buffer_full, 576'h1);
      cycles(7);
      chk("empty_early_ready", out_ready, 576'h0);
      cycles(1);
      chk("empty_ready", out_ready, 576'h1);
      clr_ew(); ew[0] = 64'h0600_0000_0000_0000; ew[8] = 64'h80;
      chk("empty_block", out, packw());
      ack();
      chk("empty_done_ready", out_ready,   576'h0);
      chk("empty_done_bf",    buffer_full, 576'h1);
      chk("empty_done_hold",  out,         packw());
      put(64'h1111_2222_3333_4444, 1'b0, 3'd0);
      chk("done_ignores_in", out, packw());
      do_reset();

      // "abc" with junk past byte 2; host keeps pushing during padding
      put(64'h6162_63AA_BBCC_DDEE, 1'b1, 3'd3);
      @(negedge clk);
      in_d = 64'hFFFF_FFFF_FFFF_FFFF; in_ready = 1'b1; is_last = 1'b1; byte_num = 3'd5;
      cycles(7);
      chk("abc_early_ready", out_ready, 576'h0);
      in_ready = 1'b0; is_last = 1'b0;
      cycles(1);
      chk("abc_ready", out_ready, 576'h1);
      clr_ew(); ew[0] = 64'h6162_6306_0000_0000; ew[8] = 64'h80;
      chk("abc_block", out, packw());
      do_reset();

      // 71 bytes: last word lands in slot 9, stray ack at cnt=4
      clr_ew();
      for (int i = 0; i < 8; i++) ew[i] = 64'h0101_0101_0101_0101 * (i + 1);
      for (int i = 0; i < 4; i++) put(ew[i], 1'b0, 3'd0);
      ack();
      chk("stray_ack_ready", out_ready,   576'h0);
      chk("stray_ack_bf",    buffer_full, 576'h0);
      for (int i = 4; i < 8; i++) put(ew[i], 1'b0, 3'd0);
      put(64'h1122_3344_5566_7788, 1'b1, 3'd7);
      ew[8] = 64'h1122_3344_5566_7786;
      chk("m71_ready", out_ready, 576'h1);
      chk("m71_block", out, packw());
      ack();
      chk("m71_done_ready", out_ready,   576'h0);
      chk("m71_done_bf",    buffer_full, 576'h1);
      do_reset();

      // 72 bytes: full block held while f_ack low, then closing empty word
      clr_ew();
      for (int i = 0; i < 9; i++) ew[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1);
      for (int i = 0; i < 9; i++) put(ew[i], 1'b0, 3'd0);
      chk("m72_ready", out_ready, 576'h1);
      chk("m72_bf",    buffer_full, 576'h1);
      @(negedge clk);
      in_d = 64'hCAFE_CAFE_CAFE_CAFE; in_ready = 1'b1;
      cycles(20);
      in_ready = 1'b0;
      chk("m72_hold_block", out, packw());
      chk("m72_hold_ready", out_ready, 576'h1);
      ack();
      chk("m72_ack_ready", out_ready,   576'h0);
      chk("m72_ack_bf",    buffer_full, 576'h0);
      put(64'h0, 1'b1, 3'd0);
      cycles(7);
      chk("m72_b2_early", out_ready, 576'h0);
      cycles(1);
      clr_ew(); ew[0] = 64'h0600_0000_0000_0000; ew[8] = 64'h80;
      chk("m72_b2_ready", out_ready, 576'h1);
      chk("m72_b2_block", out, packw());

      // reset while awaiting ack, then a 13-byte message
      do_reset();
      for (int i = 0; i < 9; i++) put(64'h5555_0000_0000_0000 | 64'(i), 1'b0, 3'd0);
      chk("prerst_ready", out_ready, 576'h1);
      do_reset();
      put(64'hFEDC_BA98_7654_3210, 1'b0, 3'd0);
      put(64'h0102_0304_0507_0809, 1'b1, 3'd5);
      cycles(6);
      chk("m13_early", out_ready, 576'h0);
      cycles(1);
      clr_ew(); ew[0] = 64'hFEDC_BA98_7654_3210; ew[1] = 64'h0102_0304_0506_0000; ew[8] = 64'h80;
      chk("m13_ready", out_ready, 576'h1);
      chk("m13_block", out, packw());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
